// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding for the bit-serial adder
package serial_adder_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/fadd.sv
// fadd: one-bit full-adder cell
module fadd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder around a single fadd cell;
// define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry, cout_r, s, c, last;
  fadd u_fadd (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(s), .cout(c));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    sum       = sum_sh;
    cout      = cout_r;
  end
  // cout is captured separately so carry can be reloaded without disturbing it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
      carry  <= c;
      cnt    <= cnt + CW'(1);
      if (last) cout_r <= c;
    end
`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                       ovf <= 1'b0;
    else if (state == RUN && last) ovf <= carry ^ c;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0, cout;
  logic [W-1:0] a = '0, b = '0, sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  int checks = 0, failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input int hold, input bit pulse);
    logic [W:0] full;
    logic [W-1:0] s0;
    logic c0;
    int n;
    full = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    @(negedge clk);
    check("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check("run_not_ready", in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      if (in_ready && out_valid) check("ready_valid_excl", 1'b1, 1'b0);
      if (pulse && n == 2) begin
        in_valid = 1'b1; a = ~ta; b = ~tb; cin = ~tc;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end
    check("latency_edges", 64'(n + 1), 64'(W + 1));
    check("done_not_ready", in_ready, 1'b0);
    check("sum", sum, full[W-1:0]);
    check("cout", cout, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
`endif
    s0 = sum; c0 = cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", sum, s0);
      check("hold_cout", cout, c0);
      check("hold_not_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle", in_ready, 1'b1);
    check("valid_drop", out_valid, 1'b0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;
    op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 0, 1'b1);
    op(8'hA5, 8'h5A, 1'b1, 5, 1'b0);
    // abort an operation just before its 4th RUN edge
    @(negedge clk);
    in_valid = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 1'b0);
    @(negedge clk); rst = 1'b0;
    op(8'h12, 8'h34, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
